// File: rtl/alu_writeback.sv
// ALU write-back stage: one-entry pending slot, register file, NZVC flags and write-back trace.
// Define ALU_WB_FORWARD_EN to forward alu_r1 onto matching read ports instead of raising hazard.
module alu_writeback #(
    parameter int unsigned REGS = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        issue_valid,
    input  logic [3:0]  issue_opcode,
    input  logic [3:0]  issue_rd,
    input  logic [15:0] alu_r1,
    input  logic        alu_negative,
    input  logic        alu_zero,
    input  logic        alu_overflow,
    input  logic        alu_carry,
    input  logic [3:0]  rd_addr_a,
    input  logic [3:0]  rd_addr_b,
    output logic [15:0] rd_data_a,
    output logic [15:0] rd_data_b,
    output logic [3:0]  flags_nzvc,
    output logic        wb_valid,
    output logic [3:0]  wb_rd,
    output logic [15:0] wb_data,
    output logic        hazard,
    output logic        err_illegal
);

    logic        pend_valid;
    logic [3:0]  pend_op;
    logic [3:0]  pend_rd;
    logic [15:0] regs [REGS];

    logic        writes_reg;
    logic        do_write;
    logic        illegal;
    logic [3:0]  flags_next;
    logic        match_a;
    logic        match_b;
    logic [15:0] raw_a;
    logic [15:0] raw_b;

    // Ops 0-8 target a register; CMP (9) only sets flags; 10-15 are illegal.
    assign writes_reg = pend_valid && (pend_op <= 4'd8);
    assign do_write   = writes_reg && (pend_rd != 4'd0);
    assign illegal    = pend_valid && (pend_op >= 4'd10);

    always_comb begin
        flags_next = flags_nzvc;
        if (pend_valid) begin
            case (pend_op)
                4'd0, 4'd1, 4'd2, 4'd9:
                    flags_next = {alu_negative, alu_zero, alu_overflow, alu_carry};
                4'd3, 4'd4, 4'd5:
                    flags_next = {alu_negative, alu_zero, flags_nzvc[1:0]};
                4'd6, 4'd7, 4'd8:
                    flags_next = {alu_negative, alu_zero, flags_nzvc[1], alu_carry};
                default:
                    flags_next = flags_nzvc;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pend_valid  <= 1'b0;
            pend_op     <= 4'd0;
            pend_rd     <= 4'd0;
            flags_nzvc  <= 4'b0000;
            wb_valid    <= 1'b0;
            wb_rd       <= 4'd0;
            wb_data     <= 16'h0000;
            err_illegal <= 1'b0;
            for (int i = 0; i < int'(REGS); i++) begin
                regs[i] <= 16'h0000;
            end
        end else begin
            pend_valid <= issue_valid;
            pend_op    <= issue_opcode;
            pend_rd    <= issue_rd;
            flags_nzvc <= flags_next;
            wb_valid   <= do_write;
            if (do_write) begin
                regs[pend_rd] <= alu_r1;
                wb_rd         <= pend_rd;
                wb_data       <= alu_r1;
            end
            if (illegal) begin
                err_illegal <= 1'b1;
            end
        end
    end

    assign raw_a   = (rd_addr_a == 4'd0) ? 16'h0000 : regs[rd_addr_a];
    assign raw_b   = (rd_addr_b == 4'd0) ? 16'h0000 : regs[rd_addr_b];
    assign match_a = do_write && (pend_rd == rd_addr_a);
    assign match_b = do_write && (pend_rd == rd_addr_b);

`ifdef ALU_WB_FORWARD_EN
    assign rd_data_a = match_a ? alu_r1 : raw_a;
    assign rd_data_b = match_b ? alu_r1 : raw_b;
    assign hazard    = 1'b0;
`else
    assign rd_data_a = raw_a;
    assign rd_data_b = raw_b;
    assign hazard    = match_a || match_b;
`endif

endmodule

// File: doc/alu_writeback.md
ALU_WRITEBACK -- requirements
Module: alu_writeback

Interface
REQ-001 SHALL have parameter REGS, default 16, meaning number of architectural registers (power of two, 4-bit address).
REQ-002 SHALL have port clk  input  1  the single clock, all state updates on posedge.
REQ-003 SHALL have port rst_n  input  1  reset, synchronous, active-low.
REQ-004 SHALL have port issue_valid  input  1  ALU instruction issued, sampled at the same posedge at which the ALU samples optcode.
REQ-005 SHALL have port issue_opcode  input  4  opcode issued to the ALU.
REQ-006 SHALL have port issue_rd  input  4  destination register of the issued instruction.
REQ-007 SHALL have port alu_r1  input  16  ALU registered result.
REQ-008 SHALL have ports alu_negative, alu_zero, alu_overflow, alu_carry  input  1 each  ALU flags.
REQ-009 SHALL have ports rd_addr_a, rd_addr_b  input  4 each  operand read addresses.
REQ-010 SHALL have ports rd_data_a, rd_data_b  output  16 each  operand read data feeding ALU R2/R3.
REQ-011 SHALL have port flags_nzvc  output  4  status register {N,Z,V,C}.
REQ-012 SHALL have ports wb_valid  output 1, wb_rd  output 4, wb_data  output 16  registered write-back trace.
REQ-013 SHALL have port hazard  output  1  a read address matches a pending, unwritten destination.
REQ-014 SHALL have port err_illegal  output  1  sticky illegal-opcode flag.

Function
REQ-015 SHALL capture pend_valid/pend_op/pend_rd from issue_valid/issue_opcode/issue_rd at every posedge (1-entry pipeline tracking ALU latency).
REQ-016 SHALL, at the posedge after capture with pend_valid=1, write alu_r1 to regfile[pend_rd] for opcodes 0-8 (2-cycle issue-to-write latency).
REQ-017 SHALL NOT write the register file for opcode 9 (CMP); flags only.
REQ-018 SHALL treat opcodes 10-15 as illegal: no write, no flag change, set err_illegal.
REQ-019 SHALL update flags: ops 0,1,2,9 -> N,Z,V,C; ops 3,4,5 -> N,Z only; ops 6,7,8 -> N,Z,C, V held.
REQ-020 SHALL ignore writes to register 0; register 0 SHALL always read 0x0000.
REQ-021 SHALL provide combinational reads of regfile; write and read of same address in one cycle returns old value unless forwarded (REQ-032).
REQ-022 SHALL drive wb_valid=1, wb_rd, wb_data for one cycle after every register write; wb_valid=0 otherwise.
REQ-023 SHALL assert hazard combinationally when pend_valid=1, pend_op in 0-8, pend_rd!=0, and pend_rd equals rd_addr_a or rd_addr_b.
REQ-024 SHALL process back-to-back issues every cycle without stall; each occupies pipeline slot independently.
REQ-025 SHALL hold err_illegal at 1 until reset.

Reset
REQ-026 SHALL, when rst_n=0 at posedge, clear pend_valid, flags_nzvc=4'b0000, wb_valid=0, wb_rd=0, wb_data=0, err_illegal=0.
REQ-027 SHALL clear all regfile entries to 0x0000 on reset.
REQ-028 SHALL discard any pending write when reset asserts mid-operation; no write after rst_n releases.
REQ-029 SHALL ignore issue_valid on the posedge where rst_n=0.

Configuration
REQ-030 SHALL use macro ALU_WB_FORWARD_EN to select operand forwarding.
REQ-031 SHALL, without ALU_WB_FORWARD_EN, return regfile contents and raise hazard per REQ-023.
REQ-032 SHALL, with ALU_WB_FORWARD_EN, return alu_r1 on a read port whose address meets REQ-023 conditions, and tie hazard to 0.

Verification
REQ-033 SHALL verify: reset, then read all addresses -> 0x0000, flags 0000, err_illegal 0.
REQ-034 SHALL verify: issue ADD rd=3, alu_r1=0x8000, N=1,V=1 -> two edges later regfile[3]=0x8000, flags=1010, wb_valid pulse wb_rd=3.
REQ-035 SHALL verify: CMP (op 9) rd=5 with alu_zero=1 -> regfile[5] unchanged, Z=1.
REQ-036 SHALL verify: op 6 with prior V=1, alu_overflow=0, carry=1 -> V stays 1, C=1.
REQ-037 SHALL verify: issue rd=4 then read addr 4 next cycle -> hazard=1 and old data (no macro); hazard=0 and alu_r1 (macro).
REQ-038 SHALL verify: op 12 issued -> no write, flags held, err_illegal=1 until rst_n=0; rst_n=0 during pending ADD rd=2 -> regfile[2]=0.
